pipeline_hazard_ctrl: RTL



---
 rtl/pipeline_hazard_ctrl_if.sv | 47 ++++
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_hazard_ctrl_if                                                  |
// | Hazard-sensing inputs and per-stage stall/flush controls bundle.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_write_addr;
  logic        ex_mem_read;
  logic [4:0]  ex_aluop;
  logic        ex_branch_taken;
  logic        imem_busywait;
  logic        dmem_busywait;
  logic        pc_stall;
  logic        ifid_busywait;
  logic        ifid_flush;
  logic        idex_busywait;
  logic        idex_bubble;
  logic        exmem_busywait;
  logic        exmem_bubble;
  logic        memwb_busywait;
  logic        muldiv_start;
  logic        muldiv_done;
  logic [31:0] stall_cycles;
  logic [15:0] bubble_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_write_addr, ex_mem_read,
           ex_aluop, ex_branch_taken, imem_busywait, dmem_busywait,
    input  pc_stall, ifid_busywait, ifid_flush, idex_busywait, idex_bubble,
           exmem_busywait, exmem_bubble, memwb_busywait, muldiv_start,
           muldiv_done, stall_cycles, bubble_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_write_addr, ex_mem_read,
           ex_aluop, ex_branch_taken, imem_busywait, dmem_busywait,
    output pc_stall, ifid_busywait, ifid_flush, idex_busywait, idex_bubble,
           exmem_busywait, exmem_bubble, memwb_busywait, muldiv_start,
           muldiv_done, stall_cycles, bubble_count
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_hazard_ctrl                                                     |
// | Stall/flush sequencer with M-extension occupancy control and counters.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  wire logic               CLK,
  input  wire logic               reset,
  pipeline_hazard_ctrl_if.slave   hz
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_MULDIV = 1'b1
  } state_t;

  localparam logic [5:0] c_MUL_N = 6'(MUL_CYCLES);
  localparam logic [5:0] c_DIV_N = 6'(DIV_CYCLES);

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_stall_cycles;
  logic [15:0] r_bubble_count;

  state_t      w_next_state;
  logic [5:0]  w_next_cnt;
  logic [5:0]  w_n;
  logic        w_freeze;
  logic        w_load_use;
  logic        w_pc_stall;
  logic        w_ifid_busywait;
  logic        w_ifid_flush;
  logic        w_idex_busywait;
  logic        w_idex_bubble;
  logic        w_exmem_busywait;
  logic        w_exmem_bubble;
  logic        w_memwb_busywait;
  logic        w_muldiv_start;
  logic        w_muldiv_done;
  logic        w_unused_aluop;

  assign w_unused_aluop = ^hz.ex_aluop[2:0];
  assign w_freeze       = hz.imem_busywait | hz.dmem_busywait;
  assign w_n            = hz.ex_aluop[3] ? c_DIV_N : c_MUL_N;
  assign w_load_use     = hz.ex_mem_read && (hz.ex_write_addr != 5'd0) &&
                          ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_write_addr)) ||
                           (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_write_addr)));

  always_comb begin
    w_pc_stall       = 1'b0;
    w_ifid_busywait  = 1'b0;
    w_ifid_flush     = 1'b0;
    w_idex_busywait  = 1'b0;
    w_idex_bubble    = 1'b0;
    w_exmem_busywait = 1'b0;
    w_exmem_bubble   = 1'b0;
    w_memwb_busywait = 1'b0;
    w_muldiv_start   = 1'b0;
    w_muldiv_done    = 1'b0;
    w_next_state     = r_state;
    w_next_cnt       = r_cnt;
    if (!reset) begin
      if (w_freeze) begin
        // Memory stall freezes the whole pipe including the M-op sequencer.
        w_pc_stall       = 1'b1;
        w_ifid_busywait  = 1'b1;
        w_idex_busywait  = 1'b1;
        w_exmem_busywait = 1'b1;
        w_memwb_busywait = 1'b1;
      end else if (hz.ex_branch_taken) begin
        w_ifid_flush  = 1'b1;
        w_idex_bubble = 1'b1;
        w_next_state  = ST_RUN;
        w_next_cnt    = 6'd0;
      end else if (r_state == ST_MULDIV) begin
        if (r_cnt != 6'd0) begin
          w_pc_stall      = 1'b1;
          w_ifid_busywait = 1'b1;
          w_idex_busywait = 1'b1;
          w_exmem_bubble  = 1'b1;
          w_next_cnt      = r_cnt - 6'd1;
        end else begin
          w_muldiv_done = 1'b1;
          w_next_state  = ST_RUN;
        end
      end else if (hz.ex_aluop[4]) begin
        w_muldiv_start = 1'b1;
        if (w_n <= 6'd1) begin
          w_muldiv_done = 1'b1;
        end else begin
          // Start cycle is the first of N; cnt covers the remaining stall cycles.
          w_pc_stall      = 1'b1;
          w_ifid_busywait = 1'b1;
          w_idex_busywait = 1'b1;
          w_exmem_bubble  = 1'b1;
          w_next_cnt      = w_n - 6'd2;
          w_next_state    = ST_MULDIV;
        end
      end else if (w_load_use) begin
        w_pc_stall      = 1'b1;
        w_ifid_busywait = 1'b1;
        w_idex_bubble   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state        <= ST_RUN;
      r_cnt          <= 6'd0;
      r_stall_cycles <= 32'd0;
      r_bubble_count <= 16'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_pc_stall) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_idex_bubble && (r_bubble_count != 16'hFFFF)) begin
        r_bubble_count <= r_bubble_count + 16'd1;
      end
    end
  end

  assign hz.pc_stall       = w_pc_stall;
  assign hz.ifid_busywait  = w_ifid_busywait;
  assign hz.ifid_flush     = w_ifid_flush;
  assign hz.idex_busywait  = w_idex_busywait;
  assign hz.idex_bubble    = w_idex_bubble;
  assign hz.exmem_busywait = w_exmem_busywait;
  assign hz.exmem_bubble   = w_exmem_bubble;
  assign hz.memwb_busywait = w_memwb_busywait;
  assign hz.muldiv_start   = w_muldiv_start;
  assign hz.muldiv_done    = w_muldiv_done;
  assign hz.stall_cycles   = r_stall_cycles;
  assign hz.bubble_count   = r_bubble_count;

endmodule
`default_nettype wire
